control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/control_pkg.sv | 35 +++
 rtl/control_decode.sv | 47 ++++
 rtl/control.sv | 41 ++++
 tb/tb_control.sv | 82 ++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: opcode encodings and the control bit bundle shared by decode and top
package control_pkg;
  localparam int OPW = 5;
  localparam logic [OPW-1:0] OP_NOP  = 5'd0;
  localparam logic [OPW-1:0] OP_ADD  = 5'd1;
  localparam logic [OPW-1:0] OP_SUB  = 5'd2;
  localparam logic [OPW-1:0] OP_MUL  = 5'd3;
  localparam logic [OPW-1:0] OP_AND  = 5'd4;
  localparam logic [OPW-1:0] OP_OR   = 5'd5;
  localparam logic [OPW-1:0] OP_XOR  = 5'd6;
  localparam logic [OPW-1:0] OP_NOT  = 5'd7;
  localparam logic [OPW-1:0] OP_LD   = 5'd8;
  localparam logic [OPW-1:0] OP_ST   = 5'd9;
  localparam logic [OPW-1:0] OP_BEQ  = 5'd10;
  localparam logic [OPW-1:0] OP_BNE  = 5'd11;
  localparam logic [OPW-1:0] OP_JMP  = 5'd12;
  localparam logic [OPW-1:0] OP_CALL = 5'd13;
  localparam logic [OPW-1:0] OP_RET  = 5'd14;
  localparam logic [OPW-1:0] OP_ADDI = 5'd15;
  typedef struct packed {
    logic branch;
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic alusrc;
    logic aluop;
    logic regdist;
    logic branchtype;
    logic push;
    logic pop;
    logic ret;
    logic jump;
  } ctrl_t;
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode to control bundle; reserved and unknown opcodes give NOP
module control_decode
  import control_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdist  = 1'b1;
        ctrl.aluop    = 1'b1;
      end
      OP_LD: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_ST: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_BEQ: ctrl.branch = 1'b1;
      OP_BNE: begin
        ctrl.branch     = 1'b1;
        ctrl.branchtype = 1'b1;
      end
      OP_JMP: ctrl.jump = 1'b1;
      OP_CALL: begin
        ctrl.jump = 1'b1;
        ctrl.push = 1'b1;
      end
      OP_RET: begin
        ctrl.ret = 1'b1;
        ctrl.pop = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/control.sv
// control: registered instruction decode with hazard bubble insertion
module control
  import control_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           hazard,
  output logic           branch,
  output logic           regwrite,
  output logic           memtoreg,
  output logic           memread,
  output logic           memwrite,
  output logic           alusrc,
  output logic           aluop,
  output logic           regdist,
  output logic           branchtype,
  output logic           push,
  output logic           pop,
  output logic           ret,
  output logic           jump
);
  ctrl_t w_ctrl;
  ctrl_t r_ctrl;
  control_decode u_decode (.opcode(opcode), .ctrl(w_ctrl));
  always_ff @(posedge clk)
    r_ctrl <= (rst || hazard) ? '0 : w_ctrl;
  assign branch     = r_ctrl.branch;
  assign regwrite   = r_ctrl.regwrite;
  assign memtoreg   = r_ctrl.memtoreg;
  assign memread    = r_ctrl.memread;
  assign memwrite   = r_ctrl.memwrite;
  assign alusrc     = r_ctrl.alusrc;
  assign aluop      = r_ctrl.aluop;
  assign regdist    = r_ctrl.regdist;
  assign branchtype = r_ctrl.branchtype;
  assign push       = r_ctrl.push;
  assign pop        = r_ctrl.pop;
  assign ret        = r_ctrl.ret;
  assign jump       = r_ctrl.jump;
endmodule

// File: tb/tb_control.sv
// tb_control: directed and randomized checks of control against a rule-based reference model
module tb_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] opcode = 5'd0;
  logic hazard = 1'b0;
  logic branch, regwrite, memtoreg, memread, memwrite, alusrc, aluop, regdist;
  logic branchtype, push, pop, ret, jump;
  int checks = 0;
  int errors = 0;
  control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .hazard(hazard),
    .branch(branch), .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread),
    .memwrite(memwrite), .alusrc(alusrc), .aluop(aluop), .regdist(regdist),
    .branchtype(branchtype), .push(push), .pop(pop), .ret(ret), .jump(jump)
  );
  always #5 clk = ~clk;
  function automatic logic [12:0] observed();
    return {branch, regwrite, memtoreg, memread, memwrite, alusrc, aluop, regdist,
            branchtype, push, pop, ret, jump};
  endfunction
  function automatic logic [12:0] model(input int op, input bit hz, input bit rs);
    bit alu;
    if (rs || hz) return '0;
    alu = op >= 1 && op <= 7;
    return {op == 10 || op == 11,
            alu || op == 8 || op == 15,
            op == 8,
            op == 8,
            op == 9,
            op == 8 || op == 9 || op == 15,
            alu,
            alu,
            op == 11,
            op == 13,
            op == 14,
            op == 14,
            op == 12 || op == 13};
  endfunction
  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input int op, input bit hz, input bit rs);
    opcode = op[4:0];
    hazard = hz;
    rst = rs;
    @(posedge clk);
    #1;
    check(tag, observed(), model(op, hz, rs));
    check({tag, "_excl"}, {memread & memwrite, push & pop, jump & ret}, 3'b000);
  endtask
  initial begin
    #1;
    step("reset0", 8, 0, 1);
    step("reset1", 8, 0, 1);
    step("rel_ld", 8, 0, 0);
    step("ld", 8, 0, 0);
    step("st", 9, 0, 0);
    step("beq", 10, 0, 0);
    step("bne", 11, 0, 0);
    step("add", 1, 0, 0);
    step("add_hold", 1, 0, 0);
    step("addi", 15, 0, 0);
    step("call", 13, 0, 0);
    step("ret", 14, 0, 0);
    step("jmp", 12, 0, 0);
    step("hz_ld", 8, 1, 0);
    step("after_hz", 8, 0, 0);
    step("rst_hz", 8, 1, 1);
    step("resume", 9, 0, 0);
    step("nop", 0, 0, 0);
    for (int i = 0; i < 32; i++) step($sformatf("sweep%0d", i), i, 0, 0);
    for (int i = 0; i < 400; i++)
      step("rand", int'($urandom_range(31)), $urandom_range(3) == 0, $urandom_range(19) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
